// File: rtl/mem_arbiter.sv
// Two-requester (fetch/execute) arbiter for one SRAM-like memory port.
// Grant is held across address stalls; responses are steered by an in-order owner FIFO.
module mem_arbiter #(
  parameter int OT_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [2:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [2:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int PW = $clog2(OT_DEPTH);
  localparam logic [PW:0] FULL_CNT = OT_DEPTH[PW:0];
  localparam logic [7:0]  LIMIT    = STARVE_LIMIT[7:0];

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  logic                lock_valid;
  owner_e              lock_owner;
  logic [OT_DEPTH-1:0] own_q;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         cnt;
  logic [7:0]          starve_cnt;

  logic   grant_vld, sel_req, starve, not_full, hs, pop;
  owner_e grant, head;

  assign starve   = (starve_cnt >= LIMIT);
  assign not_full = (cnt < FULL_CNT);

  always_comb begin
    grant_vld = 1'b0;
    grant     = OWN_DATA;
    if (lock_valid) begin
      grant_vld = 1'b1;
      grant     = lock_owner;
    end else if (data_req && !(inst_req && starve)) begin
      grant_vld = 1'b1;
      grant     = OWN_DATA;
    end else if (inst_req) begin
      grant_vld = 1'b1;
      grant     = OWN_INST;
    end
  end

  assign sel_req = (grant == OWN_INST) ? inst_req : data_req;
  assign mem_req = resetn & grant_vld & sel_req & not_full;
  assign hs      = mem_req & mem_addr_ok;

  // No grant leaves grant at OWN_DATA, so the bus shows the data side by default
  assign mem_wr    = (grant == OWN_INST) ? inst_wr    : data_wr;
  assign mem_size  = (grant == OWN_INST) ? inst_size  : data_size;
  assign mem_wstrb = (grant == OWN_INST) ? inst_wstrb : data_wstrb;
  assign mem_addr  = (grant == OWN_INST) ? inst_addr  : data_addr;
  assign mem_wdata = (grant == OWN_INST) ? inst_wdata : data_wdata;

  assign inst_addr_ok = hs & (grant == OWN_INST);
  assign data_addr_ok = hs & (grant == OWN_DATA);

  // Head is read before this cycle's push: a response never shares a cycle with its own accept
  assign head = owner_e'(own_q[rd_ptr]);
  assign pop  = resetn & mem_data_ok & (cnt != '0);

  assign inst_data_ok = pop & (head == OWN_INST);
  assign data_data_ok = pop & (head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid <= 1'b0;
      lock_owner <= OWN_INST;
      own_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      starve_cnt <= '0;
    end else begin
      // Lock only while a request is stalled; withdrawal or accept drops it
      lock_valid <= mem_req & ~mem_addr_ok;
      if (mem_req && !mem_addr_ok) lock_owner <= grant;

      if (hs) begin
        own_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({hs, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if ((hs && grant == OWN_INST) || !inst_req)
        starve_cnt <= '0;
      else if (hs && grant == OWN_DATA && starve_cnt != 8'hFF)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for FIFO-full and asynchronous reset mid-flight.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [2:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BFC = 32'hBFC0_0000;

  mem_arbiter #(.OT_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        maok, mdok;
    logic [31:0] rd;
    logic        e_req, e_wr;
    logic [31:0] e_addr;
    logic        e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic maok, mdok,
                              input logic [31:0] rd, input logic e_req, e_wr,
                              input logic [31:0] e_addr, input logic e_iaok, e_daok,
                              e_idok, e_ddok);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
    v.maok = maok; v.mdok = mdok; v.rd = rd;
    v.e_req = e_req; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_addr = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    if (v.rst) do_reset();
    @(negedge clk);
    inst_req = v.ir; inst_addr = v.ia; data_req = v.dr; data_addr = v.da;
    mem_addr_ok = v.maok; mem_data_ok = v.mdok; mem_rdata = v.rd;
    #1;
    chk($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.e_req));
    chk($sformatf("v%0d mem_wr", idx), 32'(mem_wr), 32'(v.e_wr));
    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
    chk($sformatf("v%0d inst_addr_ok", idx), 32'(inst_addr_ok), 32'(v.e_iaok));
    chk($sformatf("v%0d data_addr_ok", idx), 32'(data_addr_ok), 32'(v.e_daok));
    chk($sformatf("v%0d inst_data_ok", idx), 32'(inst_data_ok), 32'(v.e_idok));
    chk($sformatf("v%0d data_data_ok", idx), 32'(data_data_ok), 32'(v.e_ddok));
    if (v.e_idok) chk($sformatf("v%0d inst_rdata", idx), inst_rdata, v.rd);
    if (v.e_ddok) chk($sformatf("v%0d data_rdata", idx), data_rdata, v.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    inst_wr = 1'b0; inst_size = 3'd2; inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_wr = 1'b1; data_size = 3'd2; data_wstrb = 4'hF; data_wdata = 32'hA5A5_A5A5;
    idle_inputs();

    // Reset state while held and just after release
    #2;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst cnt", 32'(dut.cnt), 32'd0);
    @(negedge clk); resetn = 1'b1; #1;
    chk("rst lock_valid", 32'(dut.lock_valid), 32'd0);
    chk("rst starve_cnt", 32'(dut.starve_cnt), 32'd0);

    // Single load
    vecs.push_back(mk(1, 0, 0,   1, 32'h1000, 1, 0, 0,            1, 1, 32'h1000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0,        0, 0, 0,            0, 1, 0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0,        0, 1, 32'hDEADBEEF, 0, 1, 0,        0, 0, 0, 1));
    // Simultaneous requests: data first, responses in order
    vecs.push_back(mk(1, 1, BFC, 1, 32'h2000, 1, 0, 0,            1, 1, 32'h2000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, BFC, 0, 32'h2000, 1, 0, 0,            1, 0, BFC,      1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0,        0, 1, 32'h1111_1111, 0, 1, 0,       0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0,        0, 1, 32'h2222_2222, 0, 1, 0,       0, 0, 1, 0));
    // Lock hold: inst stalled 3 cycles, data arrives meanwhile
    vecs.push_back(mk(1, 1, BFC, 0, 0,        0, 0, 0,            1, 0, BFC,      0, 0, 0, 0));
    vecs.push_back(mk(0, 1, BFC, 1, 32'h3000, 0, 0, 0,            1, 0, BFC,      0, 0, 0, 0));
    vecs.push_back(mk(0, 1, BFC, 1, 32'h3000, 0, 0, 0,            1, 0, BFC,      0, 0, 0, 0));
    vecs.push_back(mk(0, 1, BFC, 1, 32'h3000, 1, 0, 0,            1, 0, BFC,      1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 32'h3000, 1, 0, 0,            1, 1, 32'h3000, 0, 1, 0, 0));
    // Starvation: 8 data grants, then inst wins; counter cleared afterwards
    vecs.push_back(mk(1, 1, BFC, 1, 32'h5000, 1, 0, 0,            1, 1, 32'h5000, 0, 1, 0, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(0, 1, BFC, 1, 32'h5000, 1, 1, 32'(i),     1, 1, 32'h5000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, BFC, 1, 32'h5000, 1, 1, 32'd8,        1, 0, BFC,      1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 32'h5000, 1, 1, 32'd9,        1, 1, 32'h5000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, BFC, 1, 32'h5000, 1, 0, 0,            1, 1, 32'h5000, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Outstanding full: four accepts, then blocked; a pop frees issue one cycle later
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_req = 1; data_addr = 32'h4000 + 32'(i * 4); mem_addr_ok = 1; mem_data_ok = 0;
      #1 chk($sformatf("full accept%0d", i), 32'(data_addr_ok), 32'd1);
    end
    @(negedge clk);
    mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("full mem_req", 32'(mem_req), 32'd0);
    chk("full data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("full data_data_ok", 32'(data_data_ok), 32'd1);
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    chk("resume mem_req", 32'(mem_req), 32'd1);
    chk("resume data_addr_ok", 32'(data_addr_ok), 32'd1);
    @(negedge clk);
    #1;
    chk("refull cnt", 32'(dut.cnt), 32'd4);
    chk("refull mem_req", 32'(mem_req), 32'd0);

    // Reset mid-flight with two outstanding
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_req = 1; data_addr = 32'h6000; mem_addr_ok = 1; mem_data_ok = 0;
    end
    @(negedge clk);
    data_req = 0; mem_addr_ok = 0;
    #1 chk("mid cnt before", 32'(dut.cnt), 32'd2);
    #2;
    resetn = 0;
    inst_req = 1; inst_addr = BFC; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    chk("mid rst cnt", 32'(dut.cnt), 32'd0);
    chk("mid rst mem_req", 32'(mem_req), 32'd0);
    chk("mid rst inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("mid rst data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("mid rst inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("mid rst data_data_ok", 32'(data_data_ok), 32'd0);
    @(negedge clk);
    resetn = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    chk("late inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("late data_data_ok", 32'(data_data_ok), 32'd0);
    @(negedge clk);
    mem_data_ok = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
